// File: rtl/store_buffer.sv
// Posted-write store buffer: queues stores in a DEPTH-entry FIFO, retires them on non-load cycles.
// Build option STORE_FWD_EN: forward pending store data to loads; otherwise loads hitting a pending store stall.
module store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          memWrite,
    input  logic          memRead,
    input  logic [AW-1:0] memAddress,
    input  logic [DW-1:0] writeMemData,
    output logic [DW-1:0] memData,
    output logic          stall,
    output logic          empty,
    output logic [AW-1:0] dmemAddr,
    output logic          dmemWE,
    output logic [DW-1:0] dmemWData,
    input  logic [DW-1:0] dmemRData
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic match, hit_stall, full, load_own, drain, enq;
`ifdef STORE_FWD_EN
    logic [DW-1:0] fwd_data;
`endif

    // Walk oldest to youngest so the last hit is the youngest pending store.
    always_comb begin
        logic [PW-1:0] idx;
        match = 1'b0;
`ifdef STORE_FWD_EN
        fwd_data = '0;
`endif
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PW'(k);
            if (CW'(k) < count_q && addr_q[idx] == memAddress) begin
                match = 1'b1;
`ifdef STORE_FWD_EN
                fwd_data = data_q[idx];
`endif
            end
        end
    end

    always_comb begin
`ifdef STORE_FWD_EN
        hit_stall = 1'b0;
        memData   = (match && !reset) ? fwd_data : dmemRData;
`else
        hit_stall = memRead && match && !reset;
        memData   = dmemRData;
`endif
        full      = (count_q == CW'(DEPTH));
        stall     = !reset && ((memWrite && full) || hit_stall);
        load_own  = memRead && !hit_stall;
        // Reset suppresses the drain so the reset-cycle memory write never happens.
        drain     = !reset && !load_own && (count_q != '0);
        enq       = memWrite && !stall;
        empty     = (count_q == '0);

        dmemAddr  = '0;
        dmemWData = '0;
        dmemWE    = 1'b0;
        if (load_own) begin
            dmemAddr = memAddress;
        end else if (drain) begin
            dmemAddr  = addr_q[head_q];
            dmemWData = data_q[head_q];
            dmemWE    = 1'b1;
        end
    end

    always_comb begin
        addr_d  = addr_q;
        data_d  = data_q;
        head_d  = head_q + PW'(drain);
        tail_d  = tail_q + PW'(enq);
        count_d = count_q + CW'(enq) - CW'(drain);
        if (enq) begin
            addr_d[tail_q] = memAddress;
            data_d[tail_q] = writeMemData;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: a vector table plus hand sequences for
// forwarding/hit-stall, pointer wrap against a memory model, and reset mid-drain.
module tb_store_buffer;
    logic       clk = 1'b0;
    logic       reset;
    logic       mem_write, mem_read;
    logic [7:0] mem_address, write_mem_data;
    logic [7:0] mem_data;
    logic       stall, empty;
    logic [7:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic       dmem_we;

    logic [7:0] mem [256];
    logic       use_mem;
    logic [7:0] rd_drv;
    int         wr_cnt;
    int         n_total, n_pass;

    always #5 clk = ~clk;

    assign dmem_rdata = use_mem ? mem[dmem_addr] : rd_drv;

    always @(posedge clk) begin
        if (dmem_we) begin
            mem[dmem_addr] <= dmem_wdata;
            wr_cnt         <= wr_cnt + 1;
        end
    end

    store_buffer #(.DEPTH(4), .AW(8), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .memWrite(mem_write), .memRead(mem_read),
        .memAddress(mem_address), .writeMemData(write_mem_data),
        .memData(mem_data), .stall(stall), .empty(empty),
        .dmemAddr(dmem_addr), .dmemWE(dmem_we), .dmemWData(dmem_wdata),
        .dmemRData(dmem_rdata)
    );

    typedef struct {
        logic       we, re;
        logic [7:0] addr, wd, rd;
        logic [7:0] md;
        logic       stall, empty, dwe;
        logic [7:0] daddr, dwd;
    } vec_t;

    vec_t vecs [12];
    vec_t v;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic we, input logic re, input logic [7:0] a,
                         input logic [7:0] wd, input logic [7:0] rd);
        mem_write      = we;
        mem_read       = re;
        mem_address    = a;
        write_mem_data = wd;
        rd_drv         = rd;
        #1;
    endtask

    // Inputs change at the falling edge; outputs are checked 1ns later.
    task automatic apply(input vec_t x, input string nm);
        drive(x.we, x.re, x.addr, x.wd, x.rd);
        chk({nm, ".memData"}, 16'(mem_data), 16'(x.md));
        chk({nm, ".stall"},   16'(stall),    16'(x.stall));
        chk({nm, ".empty"},   16'(empty),    16'(x.empty));
        chk({nm, ".dmemWE"},  16'(dmem_we),  16'(x.dwe));
        chk({nm, ".dmemAddr"}, 16'(dmem_addr), 16'(x.daddr));
        chk({nm, ".dmemWData"}, 16'(dmem_wdata), 16'(x.dwd));
        @(negedge clk);
    endtask

    initial begin
        int base_cnt;
        n_total = 0; n_pass = 0; wr_cnt = 0;
        use_mem = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h5A);
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst.stall",   16'(stall),    16'h0);
        chk("rst.empty",   16'(empty),    16'h1);
        chk("rst.dmemWE",  16'(dmem_we),  16'h0);
        chk("rst.dmemAddr", 16'(dmem_addr), 16'h0);
        chk("rst.memData", 16'(mem_data), 16'h5A);
        reset = 1'b0;

        //            we re addr   wd     rd     md     st em dwe daddr  dwd
        vecs[0]  = '{0, 0, 8'h00, 8'h00, 8'h5A, 8'h5A, 0, 1, 0, 8'h00, 8'h00};
        vecs[1]  = '{1, 1, 8'h10, 8'hA0, 8'h5A, 8'h5A, 0, 1, 0, 8'h10, 8'h00};
        vecs[2]  = '{1, 1, 8'h11, 8'hA1, 8'h5A, 8'h5A, 0, 0, 0, 8'h11, 8'h00};
        vecs[3]  = '{1, 1, 8'h12, 8'hA2, 8'h5A, 8'h5A, 0, 0, 0, 8'h12, 8'h00};
        vecs[4]  = '{1, 1, 8'h13, 8'hA3, 8'h5A, 8'h5A, 0, 0, 0, 8'h13, 8'h00};
        vecs[5]  = '{1, 1, 8'h14, 8'hA4, 8'h5A, 8'h5A, 1, 0, 0, 8'h14, 8'h00};
        vecs[6]  = '{1, 0, 8'h14, 8'hA4, 8'h5A, 8'h5A, 1, 0, 1, 8'h10, 8'hA0};
        vecs[7]  = '{1, 0, 8'h14, 8'hA4, 8'h5A, 8'h5A, 0, 0, 1, 8'h11, 8'hA1};
        vecs[8]  = '{0, 0, 8'h00, 8'h00, 8'h5A, 8'h5A, 0, 0, 1, 8'h12, 8'hA2};
        vecs[9]  = '{0, 0, 8'h00, 8'h00, 8'h5A, 8'h5A, 0, 0, 1, 8'h13, 8'hA3};
        vecs[10] = '{0, 0, 8'h00, 8'h00, 8'h5A, 8'h5A, 0, 0, 1, 8'h14, 8'hA4};
        vecs[11] = '{0, 0, 8'h00, 8'h00, 8'h5A, 8'h5A, 0, 1, 0, 8'h00, 8'h00};
        for (int i = 0; i < 12; i++) apply(vecs[i], $sformatf("v%0d", i));

`ifdef STORE_FWD_EN
        // Two stores to one address; the load must return the younger data.
        v = '{1, 1, 8'h20, 8'h11, 8'hFF, 8'hFF, 0, 1, 0, 8'h20, 8'h00}; apply(v, "fwd0");
        v = '{1, 1, 8'h20, 8'h22, 8'hFF, 8'h11, 0, 0, 0, 8'h20, 8'h00}; apply(v, "fwd1");
        v = '{0, 1, 8'h20, 8'h00, 8'hFF, 8'h22, 0, 0, 0, 8'h20, 8'h00}; apply(v, "fwd2");
        v = '{0, 1, 8'h21, 8'h00, 8'hFF, 8'hFF, 0, 0, 0, 8'h21, 8'h00}; apply(v, "fwd3");
        v = '{0, 0, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, 0, 1, 8'h20, 8'h11}; apply(v, "fwd4");
        v = '{0, 0, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, 0, 1, 8'h20, 8'h22}; apply(v, "fwd5");
        v = '{0, 0, 8'h00, 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 8'h00, 8'h00}; apply(v, "fwd6");
`else
        // Load hits the youngest of two pending stores: stall until both drain.
        v = '{1, 1, 8'h20, 8'h11, 8'hFF, 8'hFF, 0, 1, 0, 8'h20, 8'h00}; apply(v, "hit0");
        v = '{1, 1, 8'h21, 8'h22, 8'hFF, 8'hFF, 0, 0, 0, 8'h21, 8'h00}; apply(v, "hit1");
        v = '{0, 1, 8'h21, 8'h00, 8'hFF, 8'hFF, 1, 0, 1, 8'h20, 8'h11}; apply(v, "hit2");
        v = '{0, 1, 8'h21, 8'h00, 8'hFF, 8'hFF, 1, 0, 1, 8'h21, 8'h22}; apply(v, "hit3");
        v = '{0, 1, 8'h21, 8'h00, 8'hFF, 8'hFF, 0, 1, 0, 8'h21, 8'h00}; apply(v, "hit4");
`endif

        // Pointer wrap: count held at 2 while enqueue and drain share each cycle.
        use_mem = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, (i < 2), 8'(8'h40 + i), 8'(8'h80 + i), 8'h00);
            chk($sformatf("wrap%0d.stall", i), 16'(stall), 16'h0);
            chk($sformatf("wrap%0d.dmemWE", i), 16'(dmem_we), 16'(i >= 2));
            if (i >= 2) begin
                chk($sformatf("wrap%0d.dmemAddr", i), 16'(dmem_addr), 16'(8'h40 + i - 2));
                chk($sformatf("wrap%0d.dmemWData", i), 16'(dmem_wdata), 16'(8'h80 + i - 2));
            end
            @(negedge clk);
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
            chk($sformatf("wtail%0d.dmemAddr", i), 16'(dmem_addr), 16'(8'h46 + i));
            chk($sformatf("wtail%0d.empty", i), 16'(empty), 16'h0);
            @(negedge clk);
        end
        #1;
        chk("wrap.empty", 16'(empty), 16'h1);
        for (int i = 0; i < 8; i++)
            chk($sformatf("wrap.mem%0d", i), 16'(mem[8'h40 + i]), 16'(8'h80 + i));

        // Reset while three stores are pending and one is draining.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 8'(8'h50 + i), 8'(8'h60 + i), 8'h00);
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk("mid.dmemWE", 16'(dmem_we), 16'h1);
        chk("mid.dmemAddr", 16'(dmem_addr), 16'h50);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
        chk("rstmid.dmemWE", 16'(dmem_we), 16'h0);
        chk("rstmid.dmemAddr", 16'(dmem_addr), 16'h0);
        chk("rstmid.stall", 16'(stall), 16'h0);
        @(negedge clk);
        reset = 1'b0;
        base_cnt = wr_cnt;
        #1;
        chk("postrst.empty", 16'(empty), 16'h1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            chk($sformatf("postrst%0d.dmemWE", i), 16'(dmem_we), 16'h0);
        end
        chk("postrst.wr_cnt", 16'(wr_cnt), 16'(base_cnt));
        chk("postrst.mem50", 16'(mem[8'h50]), 16'h60);
        chk("postrst.mem51", 16'(mem[8'h51]), 16'h00);
        chk("postrst.mem52", 16'(mem[8'h52]), 16'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
